// File: rtl/m_digilent_arb.sv
// ============================================================================
// m_digilent_arb : round-robin sequencer in front of the EPP mailbox slave
// Rev 1.0
// ============================================================================
`default_nettype none

module m_digilent_arb #(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 255,
  parameter int TW       = 8
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [1:0] RQ_STB_I,
  input  logic [1:0] RQ_WE_I,
  input  logic [7:0] RQ0_DAT_I,
  input  logic [7:0] RQ1_DAT_I,
  output logic [7:0] RQ_DAT_O,
  output logic [1:0] RQ_ACK_O,
  output logic [1:0] RQ_ERR_O,
  output logic       M_STB_O,
  output logic       M_WE_O,
  output logic       M_ADR_O,
  output logic [7:0] M_DAT_O,
  input  logic [7:0] M_DAT_I,
  input  logic       M_ACK_I
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] c_GAP_LAST = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;
  localparam logic [TW-1:0] c_TMO      = TW'(TIMEOUT);
  localparam logic [TW-1:0] c_SAT      = (TIMEOUT != 0) ? TW'(TIMEOUT) : '1;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_POLL = 3'd1;
  localparam logic [2:0] c_ST_GAP  = 3'd2;
  localparam logic [2:0] c_ST_DATA = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;
  localparam logic [2:0] c_ST_FAIL = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          rr_q;
  logic          g_q;
  logic          we_q;
  logic [7:0]    dat_q;
  logic [TW-1:0] polls_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    rdat_q;

  logic          w_grant;
  logic          w_ready;

  // Lone requester wins; a tie goes to the one not served last.
  always_comb begin
    w_grant = RQ_STB_I[1];
    if (RQ_STB_I == 2'b11) begin
      w_grant = ~rr_q;
    end
  end

  assign w_ready = we_q ? ~M_DAT_I[0] : M_DAT_I[1];

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (|RQ_STB_I) state_d = c_ST_POLL;
      c_ST_POLL: begin
        if (M_ACK_I) begin
          if (w_ready) begin
            state_d = c_ST_DATA;
          end else if ((TIMEOUT != 0) && (polls_q == c_TMO)) begin
            state_d = c_ST_FAIL;
          end else if (POLL_GAP == 0) begin
            state_d = c_ST_POLL;
          end else begin
            state_d = c_ST_GAP;
          end
        end
      end
      c_ST_GAP:  if (gap_q == c_GAP_LAST) state_d = c_ST_POLL;
      // Leaving DATA on the ack guarantees a single acked data cycle.
      c_ST_DATA: if (M_ACK_I) state_d = c_ST_DONE;
      c_ST_DONE: state_d = c_ST_IDLE;
      c_ST_FAIL: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rr_q    <= 1'b1;
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      dat_q   <= 8'h00;
      polls_q <= '0;
      gap_q   <= '0;
      rdat_q  <= 8'h00;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          polls_q <= '0;
          gap_q   <= '0;
          if (|RQ_STB_I) begin
            g_q   <= w_grant;
            rr_q  <= w_grant;
            we_q  <= RQ_WE_I[w_grant];
            dat_q <= w_grant ? RQ1_DAT_I : RQ0_DAT_I;
          end
        end
        c_ST_POLL: begin
          gap_q <= '0;
          if (M_ACK_I && !w_ready && (polls_q != c_SAT)) begin
            polls_q <= polls_q + 1'b1;
          end
        end
        c_ST_GAP:  gap_q <= gap_q + 1'b1;
        c_ST_DATA: if (M_ACK_I && !we_q) rdat_q <= M_DAT_I;
        default: ;
      endcase
    end
  end

  always_comb begin
    M_STB_O  = 1'b0;
    M_ADR_O  = 1'b0;
    M_WE_O   = 1'b0;
    M_DAT_O  = 8'h00;
    RQ_ACK_O = 2'b00;
    RQ_ERR_O = 2'b00;
    case (state_q)
      c_ST_POLL: begin
        M_STB_O = 1'b1;
        M_ADR_O = 1'b1;
      end
      c_ST_DATA: begin
        M_STB_O = 1'b1;
        M_WE_O  = we_q;
        M_DAT_O = we_q ? dat_q : 8'h00;
      end
      c_ST_DONE: RQ_ACK_O = g_q ? 2'b10 : 2'b01;
      c_ST_FAIL: RQ_ERR_O = g_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign RQ_DAT_O = rdat_q;

endmodule

`default_nettype wire

// File: tb/tb_m_digilent_arb.sv
// ============================================================================
// tb_m_digilent_arb : directed-vector bench for m_digilent_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_m_digilent_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] RQ_STB_I, RQ_WE_I;
  logic [7:0] RQ0_DAT_I, RQ1_DAT_I, RQ_DAT_O;
  logic [1:0] RQ_ACK_O, RQ_ERR_O;
  logic       M_STB_O, M_WE_O, M_ADR_O, M_ACK_I;
  logic [7:0] M_DAT_O, M_DAT_I;

  always #5 clk = ~clk;

  m_digilent_arb #(.POLL_GAP(4), .TIMEOUT(3), .TW(8)) u_dut (
    .CLK_I(clk), .RST_I(rst),
    .RQ_STB_I(RQ_STB_I), .RQ_WE_I(RQ_WE_I),
    .RQ0_DAT_I(RQ0_DAT_I), .RQ1_DAT_I(RQ1_DAT_I),
    .RQ_DAT_O(RQ_DAT_O), .RQ_ACK_O(RQ_ACK_O), .RQ_ERR_O(RQ_ERR_O),
    .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ADR_O(M_ADR_O),
    .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I), .M_ACK_I(M_ACK_I)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Mailbox side: scripted status or a behavioural mailbox
  logic       real_mb = 1'b0;
  logic [7:0] stat_busy = 8'h00, stat_rdy = 8'h00, data_val = 8'h00;
  int         rdy_after = 0;
  int         n_polls = 0, n_data = 0, n_dbl = 0, n_ovf = 0, n_unf = 0, cyc = 0;
  int         poll_t[$];
  logic [7:0] last_wr = 8'h00;
  logic       dstb, prev_dstb = 1'b0;
  logic       tx_full = 1'b0, rx_full = 1'b0;
  logic [7:0] tx_byte = 8'h00, rx_byte = 8'h00;
  int         tx_tmr = 0, rx_tmr = 0, rx_idx = 0;
  logic [7:0] pc_rx[$];

  assign M_ACK_I = M_STB_O;

  always_comb begin
    if (M_ADR_O) begin
      if (real_mb) M_DAT_I = {6'b0, rx_full, tx_full};
      else         M_DAT_I = (n_polls > rdy_after) ? stat_rdy : stat_busy;
    end else begin
      M_DAT_I = real_mb ? rx_byte : data_val;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_dstb = 1'b0;
    end else begin
      if (M_STB_O && M_ACK_I && M_ADR_O) begin
        n_polls++;
        poll_t.push_back(cyc);
      end
      if (M_STB_O && M_ACK_I && !M_ADR_O) begin
        n_data++;
        if (M_WE_O) last_wr = M_DAT_O;
      end
      dstb = M_STB_O && !M_ADR_O;
      if (dstb && prev_dstb) n_dbl++;
      prev_dstb = dstb;
      chk("ackerr_onehot", 32'($onehot0(RQ_ACK_O | RQ_ERR_O)), 32'd1);
      if (!(M_STB_O && !M_ADR_O && M_WE_O)) chk("mdat_zero", M_DAT_O, 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      tx_full = 1'b0; rx_full = 1'b0; rx_byte = 8'h00;
      tx_tmr = 0; rx_tmr = 0; rx_idx = 0;
      pc_rx.delete();
    end else begin
      if (M_STB_O && M_ACK_I && !M_ADR_O) begin
        if (M_WE_O) begin
          if (tx_full) n_ovf++;
          tx_full = 1'b1; tx_byte = M_DAT_O; tx_tmr = 0;
        end else begin
          if (!rx_full) n_unf++;
          rx_full = 1'b0; rx_tmr = 0;
        end
      end
      if (tx_full) begin
        tx_tmr++;
        if (tx_tmr == 3) begin
          pc_rx.push_back(tx_byte);
          tx_full = 1'b0;
        end
      end
      if (!rx_full) begin
        rx_tmr++;
        if (rx_tmr == 3) begin
          rx_byte = 8'hC0 + 8'(rx_idx);
          rx_idx++;
          rx_full = 1'b1;
          rx_tmr = 0;
        end
      end
    end
  end

  task automatic clr_counts();
    n_polls = 0; n_data = 0; last_wr = 8'h00;
    poll_t.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RQ_STB_I = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_counts();
  endtask

  task automatic do_req(input int idx, input logic we, input logic [7:0] dat,
                        output logic [1:0] ack, output logic [1:0] err, output int lat);
    RQ_WE_I[idx] = we;
    if (idx == 0) RQ0_DAT_I = dat;
    else          RQ1_DAT_I = dat;
    RQ_STB_I[idx] = 1'b1;
    ack = 2'b00; err = 2'b00; lat = 0;
    while (lat < 200 && ack == 2'b00 && err == 2'b00) begin
      @(negedge clk);
      lat++;
      ack = RQ_ACK_O;
      err = RQ_ERR_O;
    end
    RQ_STB_I[idx] = 1'b0;
  endtask

  logic [1:0] ack, err;
  int         lat, t;

  initial begin
    rst = 1'b1;
    RQ_STB_I = 2'b00; RQ_WE_I = 2'b00; RQ0_DAT_I = 8'h00; RQ1_DAT_I = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_stb", M_STB_O, 0);
    chk("rst_ackerr", {RQ_ERR_O, RQ_ACK_O}, 0);
    chk("rst_rdat", RQ_DAT_O, 0);
    chk("rst_mbus", {M_WE_O, M_ADR_O, M_DAT_O}, 0);
    rst = 1'b0;
    clr_counts();

    // Send on an idle mailbox
    stat_busy = 8'h01; stat_rdy = 8'h00; rdy_after = 0;
    do_req(0, 1'b1, 8'hA5, ack, err, lat);
    chk("t1_ack", ack, 2'b01);
    chk("t1_err", err, 2'b00);
    chk("t1_lat", lat, 3);
    chk("t1_polls", n_polls, 1);
    chk("t1_data", n_data, 1);
    chk("t1_wr", last_wr, 8'hA5);

    // Blocked receive: ready on the fourth poll
    @(negedge clk); clr_counts();
    stat_busy = 8'h00; stat_rdy = 8'h02; rdy_after = 3; data_val = 8'h3C;
    do_req(1, 1'b0, 8'h00, ack, err, lat);
    chk("t2_ack", ack, 2'b10);
    chk("t2_rdat", RQ_DAT_O, 8'h3C);
    chk("t2_polls", n_polls, 4);
    chk("t2_lat", lat, 18);
    if (poll_t.size() == 4) begin
      chk("t2_gap1", poll_t[1] - poll_t[0], 5);
      chk("t2_gap3", poll_t[3] - poll_t[0], 15);
    end else begin
      chk("t2_polltimes", poll_t.size(), 4);
    end

    // Ties alternate, requester 0 first after reset
    do_reset();
    stat_busy = 8'h01; stat_rdy = 8'h00; rdy_after = 0;
    RQ_WE_I = 2'b11; RQ0_DAT_I = 8'h01; RQ1_DAT_I = 8'h02;
    RQ_STB_I = 2'b11;
    for (int k = 0; k < 4; k++) begin
      t = 0; ack = 2'b00;
      while (ack == 2'b00 && t < 50) begin
        @(negedge clk);
        t++;
        ack = RQ_ACK_O;
        rdy_after = n_polls;
      end
      chk("t3_order", ack, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    RQ_STB_I = 2'b00;
    repeat (2) @(negedge clk);

    // Timeout with a stuck-full transmit buffer
    clr_counts();
    stat_busy = 8'h01; rdy_after = 1000;
    do_req(0, 1'b1, 8'h77, ack, err, lat);
    chk("t4_err", err, 2'b01);
    chk("t4_ack", ack, 2'b00);
    chk("t4_polls", n_polls, 4);
    chk("t4_data", n_data, 0);
    @(negedge clk);
    chk("t4_err_once", RQ_ERR_O, 2'b00);

    // Reset during GAP
    clr_counts();
    RQ_WE_I[0] = 1'b1; RQ0_DAT_I = 8'h11; RQ_STB_I[0] = 1'b1;
    t = 0;
    while (n_polls < 1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("t5_in_gap", M_STB_O, 0);
    rst = 1'b1; RQ_STB_I = 2'b00;
    @(negedge clk);
    chk("t5g_stb", M_STB_O, 0);
    chk("t5g_ackerr", {RQ_ERR_O, RQ_ACK_O}, 0);
    rst = 1'b0;

    // Reset during DATA
    clr_counts();
    rdy_after = 0; stat_rdy = 8'h00;
    RQ_STB_I[0] = 1'b1;
    t = 0;
    while (!(M_STB_O && !M_ADR_O) && t < 50) begin @(negedge clk); t++; end
    chk("t5_in_data", {M_STB_O, M_ADR_O}, 2'b10);
    rst = 1'b1; RQ_STB_I = 2'b00;
    @(negedge clk);
    chk("t5d_stb", M_STB_O, 0);
    chk("t5d_ackerr", {RQ_ERR_O, RQ_ACK_O}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5d_idle", {RQ_ERR_O, RQ_ACK_O, M_STB_O}, 0);
    clr_counts();
    do_req(0, 1'b1, 8'h5A, ack, err, lat);
    chk("t5_ack", ack, 2'b01);
    chk("t5_lat", lat, 3);
    chk("t5_wr", last_wr, 8'h5A);

    // Behavioural mailbox stream
    do_reset();
    real_mb = 1'b1;
    n_dbl = 0; n_ovf = 0; n_unf = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        do_req(0, 1'b1, 8'h10 + 8'(i / 2), ack, err, lat);
        chk("t6_send_ack", ack, 2'b01);
      end else begin
        do_req(1, 1'b0, 8'h00, ack, err, lat);
        chk("t6_recv_ack", ack, 2'b10);
        chk("t6_recv_dat", RQ_DAT_O, 32'hC0 + 32'(i / 2));
      end
    end
    repeat (10) @(negedge clk);
    chk("t6_pc_count", pc_rx.size(), 8);
    for (int j = 0; j < 8 && j < pc_rx.size(); j++) begin
      chk("t6_pc_byte", pc_rx[j], 32'h10 + 32'(j));
    end
    chk("t6_single_stb", n_dbl, 0);
    chk("t6_overrun", n_ovf, 0);
    chk("t6_underrun", n_unf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d miscompares", n_err);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
